array_sort_check_datapath: RTL and testbench

ARRAY_SORT_CHECK_DATAPATH -- requirements
Module: array_sort_check_datapath

---
 rtl/array_sort_check_datapath.sv | 129 ++++++++++++
 tb/tb_array_sort_check_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/array_sort_check_datapath.sv
// -----------------------------------------------------------------------------
// array_sort_check_datapath
//
// Datapath for a "is this array sorted?" checker. It holds a 16 x 32-bit word
// array, a length register and a scan index. A controller walks the index
// across the array and watches inversion_found / end_of_array to decide
// whether every adjacent pair is in non-decreasing order.
//
// Build option:
//   SORT_CHECK_SIGNED_EN  defined   -> elements compared as signed 32-bit
//                         undefined -> elements compared as unsigned 32-bit
//
// Ports:
//   clock              in   rising-edge clock for all state
//   reset              in   synchronous active-high reset (length, index)
//   wr_en              in   array write strobe
//   wr_addr[3:0]       in   array write word address
//   wr_data[31:0]      in   array write data
//   length_in[4:0]     in   array length to capture (17..31 clamp to 16)
//   load_input         in   capture length_in into the length register
//   load_index         in   update the index register
//   select_index       in   index source: 0 = clear, 1 = increment (sat. 15)
//   inversion_found    out  element[index] > element[index+1]
//   end_of_array       out  no adjacent pair remains at the current index
//   zero_length_array  out  length register is 0
//   index[3:0]         out  current index register value
// -----------------------------------------------------------------------------
module array_sort_check_datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  length_in,
  input  logic        load_input,
  input  logic        load_index,
  input  logic        select_index,
  output logic        inversion_found,
  output logic        end_of_array,
  output logic        zero_length_array,
  output logic [3:0]  index
);

  localparam int unsigned DEPTH   = 16;
  localparam logic [4:0]  MAX_LEN = 5'd16;
  localparam logic [3:0]  MAX_IDX = 4'd15;

  // ---------------------------------------------------------------------------
  // Word array. Deliberately not reset: contents survive a reset so a scan can
  // be restarted over the same data.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign mem_d[gi] = (wr_en && (wr_addr == 4'(gi))) ? wr_data : mem_q[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Length and index registers.
  // ---------------------------------------------------------------------------
  logic [4:0] length_q, length_d;
  logic [3:0] index_q,  index_d;

  always_comb begin
    length_d = length_q;
    if (load_input) begin
      length_d = (length_in > MAX_LEN) ? MAX_LEN : length_in;
    end
  end

  always_comb begin
    index_d = index_q;
    if (load_index) begin
      if (!select_index) begin
        index_d = 4'd0;
      end else if (index_q != MAX_IDX) begin
        index_d = index_q + 4'd1;
      end
    end
  end

  // Reset wins over the loads; the array write above is unaffected by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      length_q <= 5'd0;
      index_q  <= 4'd0;
    end else begin
      length_q <= length_d;
      index_q  <= index_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pair compare.
  // ---------------------------------------------------------------------------
  logic [4:0]  index_plus1_wide;
  logic [3:0]  index_plus1;
  logic [31:0] elem_a;
  logic [31:0] elem_b;
  logic        a_gt_b;

  // Done at 5 bits so index 15 gives 16 (not 0) and length 0/1 read as "end".
  assign index_plus1_wide = {1'b0, index_q} + 5'd1;
  // The 4-bit wrap at index 15 only addresses word 0, and end_of_array is
  // always 1 there (length <= 16), so the compare result is masked anyway.
  assign index_plus1      = index_plus1_wide[3:0];

  assign elem_a = mem_q[index_q];
  assign elem_b = mem_q[index_plus1];

`ifdef SORT_CHECK_SIGNED_EN
  assign a_gt_b = $signed(elem_a) > $signed(elem_b);
`else
  assign a_gt_b = elem_a > elem_b;
`endif

  assign end_of_array      = (index_plus1_wide >= length_q);
  assign inversion_found   = !end_of_array && a_gt_b;
  assign zero_length_array = (length_q == 5'd0);
  assign index             = index_q;

endmodule

// File: tb/tb_array_sort_check_datapath.sv
module tb_array_sort_check_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  length_in;
  logic        load_input;
  logic        load_index;
  logic        select_index;
  logic        inversion_found;
  logic        end_of_array;
  logic        zero_length_array;
  logic [3:0]  index;

  int tests_run    = 0;
  int tests_failed = 0;

  array_sort_check_datapath dut (
    .clock             (clock),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .length_in         (length_in),
    .load_input        (load_input),
    .load_index        (load_index),
    .select_index      (select_index),
    .inversion_found   (inversion_found),
    .end_of_array      (end_of_array),
    .zero_length_array (zero_length_array),
    .index             (index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, act);
    end
  endtask

  // One clock: inputs driven before the call are sampled on this edge, then
  // strobes drop and outputs settle 1 ns after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    reset      = 1'b0;
    wr_en      = 1'b0;
    load_input = 1'b0;
    load_index = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
  endtask

  // Load a length and clear the index in the same cycle.
  task automatic start_scan(input logic [4:0] len);
    length_in    = len;
    load_input   = 1'b1;
    load_index   = 1'b1;
    select_index = 1'b0;
    cyc();
  endtask

  task automatic inc();
    load_index   = 1'b1;
    select_index = 1'b1;
    cyc();
  endtask

  task automatic check_all(input string tag, input logic inv, input logic eoa,
                           input logic zl, input logic [3:0] idx);
    check({tag, ".inv"},  32'(inversion_found),   32'(inv));
    check({tag, ".eoa"},  32'(end_of_array),      32'(eoa));
    check({tag, ".zlen"}, 32'(zero_length_array), 32'(zl));
    check({tag, ".idx"},  32'(index),             32'(idx));
  endtask

  logic [31:0] vec_a [4];
  logic        exp_signed_pair;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    length_in = '0; load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;

    // Reset then idle.
    reset = 1'b1; cyc();
    reset = 1'b1; cyc();
    cyc();
    check_all("rst_idle", 1'b0, 1'b1, 1'b1, 4'd0);

    // Sorted {1,2,3,4}.
    vec_a[0] = 32'd1; vec_a[1] = 32'd2; vec_a[2] = 32'd3; vec_a[3] = 32'd4;
    for (int i = 0; i < 4; i++) wr(4'(i), vec_a[i]);
    start_scan(5'd4);
    check_all("sorted_i0", 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i < 4; i++) begin
      inc();
      check_all($sformatf("sorted_i%0d", i), 1'b0, (i == 3), 1'b0, 4'(i));
    end

    // {5,7,6}: inversion at index 1.
    wr(4'd0, 32'd5); wr(4'd1, 32'd7); wr(4'd2, 32'd6);
    start_scan(5'd3);
    check_all("576_i0", 1'b0, 1'b0, 1'b0, 4'd0);
    inc();
    check_all("576_i1", 1'b1, 1'b0, 1'b0, 4'd1);
    // Write index+1 mid-scan: 7 vs 9 is no longer an inversion; index holds.
    wr(4'd2, 32'd9);
    check_all("576_wr_i1", 1'b0, 1'b0, 1'b0, 4'd1);
    // Equal elements are not an inversion.
    wr(4'd2, 32'd7);
    check_all("576_eq_i1", 1'b0, 1'b0, 1'b0, 4'd1);
    wr(4'd2, 32'd6);
    check("576_restore.inv", 32'(inversion_found), 32'd1);
    inc();
    check_all("576_i2", 1'b0, 1'b1, 1'b0, 4'd2);

    // 0xFFFFFFFF vs 1: signedness of the compare.
`ifdef SORT_CHECK_SIGNED_EN
    exp_signed_pair = 1'b0;
`else
    exp_signed_pair = 1'b1;
`endif
    wr(4'd0, 32'hFFFF_FFFF); wr(4'd1, 32'h0000_0001);
    start_scan(5'd2);
    check_all("sign_i0", exp_signed_pair, 1'b0, 1'b0, 4'd0);
    wr(4'd1, 32'hFFFF_FFFF);
    check("sign_eq.inv", 32'(inversion_found), 32'd0);

    // Length 1: end immediately, contents irrelevant.
    wr(4'd1, 32'd0);
    start_scan(5'd1);
    check_all("len1", 1'b0, 1'b1, 1'b0, 4'd0);

    // length_in=20 clamps to 16; index saturates at 15.
    for (int i = 0; i < 16; i++) wr(4'(i), 32'(100 + i));
    start_scan(5'd20);
    for (int i = 1; i <= 20; i++) begin
      inc();
      check($sformatf("sat_%0d.idx", i), 32'(index), (i > 15) ? 32'd15 : 32'(i));
      check($sformatf("sat_%0d.eoa", i), 32'(end_of_array), (i >= 15) ? 32'd1 : 32'd0);
    end

    // Reset mid-scan with load_index/increment, load_input and a write.
    wr(4'd0, 32'd10); wr(4'd1, 32'd30); wr(4'd2, 32'd20); wr(4'd3, 32'd40);
    start_scan(5'd4);
    inc(); inc();
    check_all("pre_rst_i2", 1'b0, 1'b0, 1'b0, 4'd2);
    reset = 1'b1; load_index = 1'b1; select_index = 1'b1;
    load_input = 1'b1; length_in = 5'd5;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd7;
    cyc();
    check_all("mid_rst", 1'b0, 1'b1, 1'b1, 4'd0);
    // Reload length only; index stays 0 and the array must be intact.
    length_in = 5'd4; load_input = 1'b1; cyc();
    check_all("post_rst_i0", 1'b0, 1'b0, 1'b0, 4'd0);
    inc();
    check_all("post_rst_i1", 1'b1, 1'b0, 1'b0, 4'd1);
    inc();
    check_all("post_rst_i2", 1'b1, 1'b0, 1'b0, 4'd2);
    inc();
    check_all("post_rst_i3", 1'b0, 1'b1, 1'b0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
